// File: rtl/bcd_converter_pkg.sv
// Shared display-path types for the binary-to-BCD converter.
// Holds the FSM state type, nibble width and the digit-count helper.
package bcd_converter_pkg;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   localparam int BCD_NIBBLE_W = 4;

   // Smallest digit count d with 10^d > 2^in_w.
   function automatic int digits_needed(input int in_w);
      longint unsigned lim;
      longint unsigned p;
      int d;
      lim = 64'd1 << in_w;
      p = 64'd1;
      d = 0;
      while (p <= lim) begin
         p = p * 64'd10;
         d++;
      end
      return d;
   endfunction

endpackage

// File: rtl/bcd_converter_digit_adjust.sv
// Double-dabble nibble correction: a digit of 5..9 gets +3
// so that the following left shift carries into the next digit.
module bcd_digit_adjust
   import bcd_converter_pkg::*;
(
   input  logic [BCD_NIBBLE_W-1:0] nib,
   output logic [BCD_NIBBLE_W-1:0] adj
);

   always_comb begin
      adj = nib;
      if (nib >= BCD_NIBBLE_W'(5)) adj = nib + BCD_NIBBLE_W'(3);
   end

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with sign
// and leading-zero mask, feeding the per-digit 7-segment decoders.
module bcd_converter
   import bcd_converter_pkg::*;
#(
   parameter int IN_W   = 12,
   parameter int DIGITS = 4,
   parameter bit SIGNED = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [IN_W-1:0]                din,
   output logic                           busy,
   output logic                           done,
   output logic [BCD_NIBBLE_W*DIGITS-1:0] bcd_out,
   output logic                           sign_out,
   output logic [DIGITS-1:0]              lz_mask
);

   localparam int BW = BCD_NIBBLE_W * DIGITS;
   localparam int CW = $clog2(IN_W + 1);
   localparam logic [DIGITS-1:0] LZ_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   if (DIGITS < digits_needed(IN_W)) begin : g_bad_digits
      $fatal(1, "bcd_converter: DIGITS too small for IN_W");
   end

   state_t          state;
   logic [BW-1:0]   work;
   logic [IN_W-1:0] mag;
   logic [CW-1:0]   count;
   logic            neg;

   logic [BW-1:0]     adj;
   logic [BW-1:0]     nxt_work;
   logic [IN_W-1:0]   nxt_mag;
   logic [IN_W-1:0]   in_mag;
   logic [DIGITS-1:0] nxt_lz;
   logic              in_neg;
   logic              unused_msb;

   for (genvar k = 0; k < DIGITS; k++) begin : g_adj
      bcd_digit_adjust u_adj (
         .nib (work[k*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
         .adj (adj[k*BCD_NIBBLE_W +: BCD_NIBBLE_W])
      );
   end

   // Top adjusted bit never carries out when DIGITS is large enough.
   assign unused_msb = adj[BW-1];
   assign nxt_work   = {adj[BW-2:0], mag[IN_W-1]};
   assign nxt_mag    = {mag[IN_W-2:0], 1'b0};

   assign in_neg = SIGNED && din[IN_W-1];
   assign in_mag = in_neg ? (~din + IN_W'(1)) : din;

   always_comb begin
      logic hi;
      hi = 1'b1;
      nxt_lz = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         hi = hi && (nxt_work[k*BCD_NIBBLE_W +: BCD_NIBBLE_W] == '0);
         nxt_lz[k] = hi;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         work     <= '0;
         mag      <= '0;
         count    <= '0;
         neg      <= 1'b0;
         bcd_out  <= '0;
         sign_out <= 1'b0;
         lz_mask  <= LZ_RST;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  mag   <= in_mag;
                  work  <= '0;
                  count <= CW'(IN_W);
                  neg   <= in_neg;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               work  <= nxt_work;
               mag   <= nxt_mag;
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  bcd_out  <= nxt_work;
                  lz_mask  <= nxt_lz;
                  sign_out <= neg && (nxt_work != '0);
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_converter.sv
// Bench for bcd_converter: unsigned and signed instances share stimulus,
// expected results go through per-instance queues.
module tb_bcd_converter;

   typedef struct packed {
      logic        sign;
      logic [15:0] bcd;
      logic [3:0]  lz;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] din;

   logic        busy_u, done_u, sign_u;
   logic [15:0] bcd_u;
   logic [3:0]  lz_u;
   logic        busy_s, done_s, sign_s;
   logic [15:0] bcd_s;
   logic [3:0]  lz_s;

   res_t q_u[$];
   res_t q_s[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ecnt  = 0;

   always #5 clk = ~clk;

   bcd_converter #(.IN_W(12), .DIGITS(4), .SIGNED(1'b0)) u_uns (
      .clk(clk), .rst(rst), .start(start), .din(din),
      .busy(busy_u), .done(done_u), .bcd_out(bcd_u),
      .sign_out(sign_u), .lz_mask(lz_u)
   );

   bcd_converter #(.IN_W(12), .DIGITS(4), .SIGNED(1'b1)) u_sgn (
      .clk(clk), .rst(rst), .start(start), .din(din),
      .busy(busy_s), .done(done_s), .bcd_out(bcd_s),
      .sign_out(sign_s), .lz_mask(lz_s)
   );

   function automatic res_t model(input logic [11:0] v, input bit sg);
      res_t r;
      logic [11:0] n;
      int m;
      bit hi;
      n = v;
      if (sg && v[11]) n = ~v + 12'd1;
      m = int'(n);
      r.bcd = '0;
      for (int k = 0; k < 4; k++) begin
         r.bcd[k*4 +: 4] = 4'(m % 10);
         m = m / 10;
      end
      r.sign = sg && v[11] && (n != 12'd0);
      r.lz = '0;
      hi = 1'b1;
      for (int k = 3; k >= 1; k--) begin
         hi = hi && (r.bcd[k*4 +: 4] == 4'd0);
         r.lz[k] = hi;
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      ecnt++;
   endtask

   task automatic kick(input logic [11:0] v);
      @(posedge clk);
      #1;
      start = 1'b1;
      din   = v;
      q_u.push_back(model(v, 1'b0));
      q_s.push_back(model(v, 1'b1));
      @(posedge clk);
      #1;
      start = 1'b0;
      ecnt  = 1;
   endtask

   task automatic wait_done();
      while (!(done_u && done_s) && ecnt < 40) step();
   endtask

   task automatic test_reset();
      res_t e;
      e = '{sign: 1'b0, bcd: 16'h0000, lz: 4'b1110};
      rst = 1'b1;
      start = 1'b0;
      din = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy_u, done_u, sign_u, bcd_u, lz_u} !== {2'b00, e}) begin
         $display("FAIL reset_uns got %b_%b_%b_%h_%b",
                  busy_u, done_u, sign_u, bcd_u, lz_u);
         n_bad++;
      end
      n_cmp++;
      if ({busy_s, done_s, sign_s, bcd_s, lz_s} !== {2'b00, e}) begin
         $display("FAIL reset_sgn got %b_%b_%b_%h_%b",
                  busy_s, done_s, sign_s, bcd_s, lz_s);
         n_bad++;
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_conversions();
      logic [11:0] tbl[5];
      res_t eu, es;
      tbl = '{12'd4095, 12'h800, 12'hFFF, 12'd9, 12'd0};
      foreach (tbl[i]) begin
         kick(tbl[i]);
         n_cmp++;
         if (!(busy_u && busy_s)) begin
            $display("FAIL busy_%0d got %b/%b want 1", i, busy_u, busy_s);
            n_bad++;
         end
         wait_done();
         n_cmp++;
         if (ecnt !== 13) begin
            $display("FAIL latency_%0d got %0d want 13", i, ecnt);
            n_bad++;
         end
         eu = q_u.pop_front();
         es = q_s.pop_front();
         n_cmp++;
         if ({sign_u, bcd_u, lz_u} !== eu) begin
            $display("FAIL conv_uns_%h got %b_%h_%b want %b_%h_%b", tbl[i],
                     sign_u, bcd_u, lz_u, eu.sign, eu.bcd, eu.lz);
            n_bad++;
         end
         n_cmp++;
         if ({sign_s, bcd_s, lz_s} !== es) begin
            $display("FAIL conv_sgn_%h got %b_%h_%b want %b_%h_%b", tbl[i],
                     sign_s, bcd_s, lz_s, es.sign, es.bcd, es.lz);
            n_bad++;
         end
         step();
         n_cmp++;
         if (done_u || done_s || busy_u || busy_s) begin
            $display("FAIL after_done_%0d got done %b/%b busy %b/%b want 0",
                     i, done_u, done_s, busy_u, busy_s);
            n_bad++;
         end
      end
   endtask

   task automatic test_ignore_start();
      int ndone = 0;
      int lat = 0;
      res_t e;
      kick(12'd1234);
      repeat (30) begin
         start = (ecnt == 5);
         if (ecnt == 5) din = 12'h077;
         step();
         if (done_u) begin
            ndone++;
            lat = ecnt;
            e = q_u.pop_front();
            void'(q_s.pop_front());
            n_cmp++;
            if ({sign_u, bcd_u, lz_u} !== e) begin
               $display("FAIL ignore_result got %h want %h", bcd_u, e.bcd);
               n_bad++;
            end
         end
      end
      start = 1'b0;
      n_cmp++;
      if (ndone !== 1 || lat !== 13) begin
         $display("FAIL ignore_done got %0d pulses at %0d want 1 at 13",
                  ndone, lat);
         n_bad++;
      end
   endtask

   task automatic test_abort();
      int ndone = 0;
      res_t e;
      kick(12'd1234);
      while (ecnt < 5) step();
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy_u, done_u, sign_u, bcd_u, lz_u} !==
          {2'b00, 1'b0, 16'h0000, 4'b1110}) begin
         $display("FAIL abort_reset got %b_%b_%b_%h_%b",
                  busy_u, done_u, sign_u, bcd_u, lz_u);
         n_bad++;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      q_u.delete();
      q_s.delete();
      repeat (20) begin
         step();
         if (done_u || done_s) ndone++;
      end
      n_cmp++;
      if (ndone !== 0) begin
         $display("FAIL abort_no_done got %0d want 0", ndone);
         n_bad++;
      end
      kick(12'd1234);
      wait_done();
      e = q_u.pop_front();
      void'(q_s.pop_front());
      n_cmp++;
      if (ecnt !== 13 || bcd_u !== e.bcd || bcd_u !== 16'h1234) begin
         $display("FAIL abort_rerun got %h at %0d want %h at 13",
                  bcd_u, ecnt, e.bcd);
         n_bad++;
      end
   endtask

   task automatic test_back_to_back();
      res_t e1, e2;
      @(posedge clk);
      #1;
      start = 1'b1;
      din   = 12'd100;
      q_u.push_back(model(12'd100, 1'b0));
      q_s.push_back(model(12'd100, 1'b1));
      step();
      ecnt = 1;
      wait_done();
      e1 = q_u.pop_front();
      void'(q_s.pop_front());
      n_cmp++;
      if (ecnt !== 13 || {sign_u, bcd_u, lz_u} !== e1) begin
         $display("FAIL b2b_first got %h at %0d want %h at 13",
                  bcd_u, ecnt, e1.bcd);
         n_bad++;
      end
      din = 12'd200;
      q_u.push_back(model(12'd200, 1'b0));
      q_s.push_back(model(12'd200, 1'b1));
      step();
      start = 1'b0;
      ecnt  = 1;
      n_cmp++;
      if (!busy_u) begin
         $display("FAIL b2b_restart got busy %b want 1", busy_u);
         n_bad++;
      end
      while (ecnt < 6) step();
      n_cmp++;
      if ({sign_u, bcd_u, lz_u} !== e1) begin
         $display("FAIL b2b_hold got %h want %h", bcd_u, e1.bcd);
         n_bad++;
      end
      wait_done();
      e2 = q_u.pop_front();
      void'(q_s.pop_front());
      n_cmp++;
      if (ecnt !== 13 || {sign_u, bcd_u, lz_u} !== e2) begin
         $display("FAIL b2b_second got %h at %0d want %h at 13",
                  bcd_u, ecnt, e2.bcd);
         n_bad++;
      end
   endtask

   initial begin
      test_reset();
      test_conversions();
      test_ignore_start();
      test_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
